// File: rtl/rr_arb_8.sv
// Eight-requester arbiter: round-robin or fixed-priority (bit 7 highest) selection,
// registered one-hot grant with binary index, tenure bounded by MAX_HOLD cycles.
module rr_arb_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rr_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             expired_q, expired_d;

    logic             rr_found;
    logic [2:0]       rr_idx;
    logic [2:0]       fp_idx;
    logic [2:0]       winner;

    // Round-robin scans upward from ptr (inclusive) and wraps; fixed priority keeps the highest set bit.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        fp_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!rr_found && req[ptr_q + 3'(i)]) begin
                rr_found = 1'b1;
                rr_idx   = ptr_q + 3'(i);
            end
            if (req[i]) begin
                fp_idx = 3'(i);
            end
        end
        winner = rr_mode ? rr_idx : fp_idx;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        expired_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req != 8'd0) begin
                    state_d     = GRANT;
                    gnt_d       = 8'd1 << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    ptr_d       = winner + 3'd1;
                    hold_cnt_d  = CNT_W'(1);
                end
            end
            GRANT: begin
                // Only the current owner's request matters until the tenure ends.
                if (!req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    expired_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            expired_q   <= expired_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_rr_arb_8.sv
// Self-checking bench for rr_arb_8: per-cycle expected outputs are queued when
// inputs are driven and compared after the following rising edge.
module tb_rr_arb_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       expired;

    int checks   = 0;
    int failures = 0;
    bit inv_on   = 1'b0;

    typedef struct packed {
        logic [7:0] req;
        logic       mode;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       exp;
    } vec_t;

    logic [12:0] sb_q[$];
    vec_t        tbl[$];

    rr_arb_8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rr_mode  (rr_mode),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .expired  (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic cyc(input logic [7:0] r, input logic m, input logic [7:0] eg,
                       input logic [2:0] eid, input logic ev, input logic ee, input string name);
        logic [12:0] exp_v;
        @(negedge clk);
        req     = r;
        rr_mode = m;
        sb_q.push_back({eg, eid, ev, ee});
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        check(name, {3'b0, gnt, gnt_id, gnt_valid, expired}, {3'b0, exp_v});
    endtask

    always @(negedge clk) begin
        if (inv_on && rst_n) begin
            check("inv_onehot", 16'($onehot0(gnt)), 16'd1);
            check("inv_id_valid", 16'(gnt[gnt_id]), 16'(gnt_valid));
        end
    end

    initial begin
        int id;

        tbl.push_back('{8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{8'h03, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h03, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{8'h16, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{8'h16, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0});
        tbl.push_back('{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0});

        rst_n   = 1'b0;
        req     = 8'hFF;
        rr_mode = 1'b1;
        for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "reset_hold");
        rst_n  = 1'b1;
        inv_on = 1'b1;
        for (int i = 0; i < 2; i++) cyc(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "reset_idle");

        foreach (tbl[i]) begin
            cyc(tbl[i].req, tbl[i].mode, tbl[i].gnt, tbl[i].id, tbl[i].valid, tbl[i].exp,
                $sformatf("table_%0d", i));
        end

        // Round-robin rotation from ptr=0: ids 0..7 then 0, each 16 cycles then an expired idle cycle.
        for (int t = 0; t < 9; t++) begin
            id = t % 8;
            for (int c = 0; c < 16; c++)
                cyc(8'hFF, 1'b1, 8'(1 << id), 3'(id), 1'b1, 1'b0, $sformatf("rr_t%0d_c%0d", t, c + 1));
            cyc(8'hFF, 1'b1, 8'h00, 3'(id), 1'b0, 1'b1, $sformatf("rr_t%0d_expire", t));
        end

        // Hold-limit boundary: full 16-cycle tenure then forced release; next tenure dropped in cycle 16.
        for (int c = 0; c < 16; c++) cyc(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, $sformatf("hold_a_c%0d", c + 1));
        cyc(8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b1, "hold_a_expire");
        for (int c = 0; c < 16; c++) cyc(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, $sformatf("hold_b_c%0d", c + 1));
        cyc(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "hold_b_drop16");
        cyc(8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "hold_b_idle");

        // Fixed priority: id 7 wins repeatedly, then id 5 once bit 7 clears.
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 16; c++)
                cyc(8'hAA, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, $sformatf("fp_t%0d_c%0d", t, c + 1));
            cyc(8'hAA, 1'b0, 8'h00, 3'd7, 1'b0, 1'b1, $sformatf("fp_t%0d_expire", t));
        end
        for (int c = 0; c < 3; c++) cyc(8'h2A, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, $sformatf("fp_id5_c%0d", c + 1));

        // Asynchronous reset between edges while gnt=8'h20.
        #1;
        rst_n   = 1'b0;
        req     = 8'h21;
        rr_mode = 1'b1;
        #1;
        check("async_rst_gnt", 16'(gnt), 16'h0000);
        check("async_rst_valid_id", {12'd0, gnt_valid, gnt_id}, 16'h0000);
        #1;
        rst_n = 1'b1;
        cyc(8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "post_rst_first");
        cyc(8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "post_rst_hold");
        cyc(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "post_rst_release");
        cyc(8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "post_rst_rr_next");
        cyc(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, "post_rst_end");

        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
